// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and constants for the bit-serial adder.
//   sa_state_t       : controller state encoding (IDLE, RUN, DONE)
//   SA_DEFAULT_WIDTH : default operand/sum width in bits
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa.sv
// ---------------------------------------------------------------------------
// fa
// Combinational full adder built from two half adders and an OR gate.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit   (a ^ b ^ ci)
//   co   : carry out ((a & b) | ((a ^ b) & ci))
// ---------------------------------------------------------------------------
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;   // propagate: a ^ b
  logic g0;  // generate from the operand pair
  logic g1;  // carry produced by propagating ci

  ha u_ha0 (
    .x (a),
    .y (b),
    .s (p),
    .c (g0)
  );

  ha u_ha1 (
    .x (p),
    .y (ci),
    .s (s),
    .c (g1)
  );

  // The two half-adder carries can never both be 1, so OR is sufficient.
  assign co = g0 | g1;

endmodule

// File: rtl/ha.sv
// ---------------------------------------------------------------------------
// ha
// Combinational half adder.
//   x, y : input bits
//   s    : sum bit   (x ^ y)
//   c    : carry bit (x & y)
// ---------------------------------------------------------------------------
module ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder: one full-adder cell reused WIDTH times, LSB
// first. Operands are taken over an in_valid/in_ready handshake, the result
// is returned over an out_valid/out_ready handshake.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : a, b, cin are valid
//   in_ready   : ready to accept operands (IDLE only)
//   a, b       : WIDTH-bit operands
//   cin        : carry in
//   out_valid  : sum/cout valid (DONE only)
//   out_ready  : consumer takes the result
//   sum        : registered a + b + cin mod 2^WIDTH
//   cout       : registered carry out of bit WIDTH-1
//   busy       : high in RUN or DONE
// ---------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sa_state_t        state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;

  logic             fa_s;
  logic             fa_c;

  // The single shared adder cell always looks at the current LSBs.
  fa u_fa (
    .a  (a_sr_reg[0]),
    .b  (b_sr_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sr_reg  <= a;
            b_sr_reg  <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end

        RUN: begin
          a_sr_reg  <= a_sr_reg >> 1;
          b_sr_reg  <= b_sr_reg >> 1;
          // New sum bits enter at the MSB; after WIDTH shifts bit 0 of the
          // result has reached position 0.
          sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
          carry_reg <= fa_c;
          if (cnt_reg == LAST_BIT) begin
            cout_reg  <= fa_c;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs depend on the state register only.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == RUN) || (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder: directed vectors on a WIDTH=8
// instance, then randomized traffic with stalls on WIDTH=8 and WIDTH=13
// instances, each against a queue of golden a+b+cin results.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W8   = 8;
  localparam int W13  = 13;
  localparam int NRND = 500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance signals
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W8-1:0] a;
  logic [W8-1:0] b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W8-1:0] sum;
  logic          cout;
  logic          busy;

  // WIDTH=13 instance signals
  logic           rst13;
  logic           in_valid13;
  logic           in_ready13;
  logic [W13-1:0] a13;
  logic [W13-1:0] b13;
  logic           cin13;
  logic           out_valid13;
  logic           out_ready13;
  logic [W13-1:0] sum13;
  logic           cout13;
  logic           busy13;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(W8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  serial_adder #(.WIDTH(W13)) u_dut13 (
    .clk       (clk),
    .rst       (rst13),
    .in_valid  (in_valid13),
    .in_ready  (in_ready13),
    .a         (a13),
    .b         (b13),
    .cin       (cin13),
    .out_valid (out_valid13),
    .out_ready (out_ready13),
    .sum       (sum13),
    .cout      (cout13),
    .busy      (busy13)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One complete operation with out_ready held high.
  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] es, input logic ec);
    int lat;
    @(negedge clk);
    a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b1;
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'd9);
    check_eq({tag, "_sum"}, 64'(sum), 64'(es));
    check_eq({tag, "_cout"}, 64'(cout), 64'(ec));
    $display("op %s: %02h + %02h + %0d -> sum=%02h cout=%0d", tag, va, vb, vc, sum, cout);
    @(negedge clk);
    check_eq({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    check_eq({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic rnd8_run();
    int sent = 0;
    int recv = 0;
    int extra = 0;
    logic acc = 1'b0;
    logic [W8:0] exp_cur;
    logic [W8:0] exp_q[$];
    logic [W8:0] e;
    a = W8'($urandom); b = W8'($urandom); cin = 1'($urandom_range(0, 1));
    exp_cur = {1'b0, a} + {1'b0, b} + (W8+1)'(cin);
    for (int cyc = 0; cyc < 30 * NRND && recv < NRND; cyc++) begin
      @(negedge clk);
      if (acc) begin
        exp_q.push_back(exp_cur);
        sent++;
        a = W8'($urandom); b = W8'($urandom); cin = 1'($urandom_range(0, 1));
        exp_cur = {1'b0, a} + {1'b0, b} + (W8+1)'(cin);
      end
      in_valid  = (sent < NRND) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          e = exp_q.pop_front();
          check_eq("rnd8", 64'({cout, sum}), 64'(e));
          $display("rnd8 #%0d: result {cout,sum}=%03h", recv, {cout, sum});
        end
        recv++;
      end
    end
    in_valid = 1'b0;
    check_eq("rnd8_count", 64'(recv), 64'(NRND));
    check_eq("rnd8_extra", 64'(extra), 64'd0);
    check_eq("rnd8_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rnd13_run();
    int sent = 0;
    int recv = 0;
    int extra = 0;
    logic acc = 1'b0;
    logic [W13:0] exp_cur;
    logic [W13:0] exp_q[$];
    logic [W13:0] e;
    a13 = W13'($urandom); b13 = W13'($urandom); cin13 = 1'($urandom_range(0, 1));
    exp_cur = {1'b0, a13} + {1'b0, b13} + (W13+1)'(cin13);
    for (int cyc = 0; cyc < 30 * NRND && recv < NRND; cyc++) begin
      @(negedge clk);
      if (acc) begin
        exp_q.push_back(exp_cur);
        sent++;
        a13 = W13'($urandom); b13 = W13'($urandom); cin13 = 1'($urandom_range(0, 1));
        exp_cur = {1'b0, a13} + {1'b0, b13} + (W13+1)'(cin13);
      end
      in_valid13  = (sent < NRND) && ($urandom_range(0, 3) != 0);
      out_ready13 = ($urandom_range(0, 2) != 0);
      acc = in_valid13 && in_ready13;
      if (out_valid13 && out_ready13) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          e = exp_q.pop_front();
          check_eq("rnd13", 64'({cout13, sum13}), 64'(e));
          $display("rnd13 #%0d: result {cout,sum}=%04h", recv, {cout13, sum13});
        end
        recv++;
      end
    end
    in_valid13 = 1'b0;
    check_eq("rnd13_count", 64'(recv), 64'(NRND));
    check_eq("rnd13_extra", 64'(extra), 64'd0);
    check_eq("rnd13_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int lat;
    int acc_cyc[$];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    rst13 = 1'b1; in_valid13 = 1'b0; out_ready13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_sum", 64'(sum), 64'd0);
    check_eq("rst_cout", 64'(cout), 64'd0);
    rst = 1'b0; rst13 = 1'b0;

    // Directed sums
    run_op("op3c05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
    run_op("opff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("opffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Backpressure: result held while new operands are offered
    @(negedge clk);
    a = 8'hC0; b = 8'h7F; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check_eq("bp_reach_done", 64'(out_valid), 64'd1);
    a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_out_valid", 64'(out_valid), 64'd1);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_sum", 64'(sum), 64'h40);
      check_eq("bp_cout", 64'(cout), 64'd1);
    end
    $display("op bp: c0 + 7f + 1 -> sum=%02h cout=%0d held 5 cycles", sum, cout);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", 64'(in_ready), 64'd1);
    check_eq("bp_release_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_eq("bp_new_accept", 64'(busy), 64'd1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check_eq("bp_new_sum", 64'(sum), 64'h03);
    check_eq("bp_new_cout", 64'(cout), 64'd0);
    $display("op bp2: 01 + 02 + 0 -> sum=%02h cout=%0d", sum, cout);
    @(negedge clk);

    // Asynchronous reset during RUN
    a = 8'h3C; b = 8'h05; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 64'(out_valid), 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_in_ready", 64'(in_ready), 64'd1);
    check_eq("arst_sum", 64'(sum), 64'd0);
    check_eq("arst_cout", 64'(cout), 64'd0);
    $display("op arst: reset mid-RUN, sum=%02h busy=%0d", sum, busy);
    @(negedge clk);
    rst = 1'b0;
    run_op("op1020", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    // Throughput with in_valid and out_ready tied high
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid) begin
        check_eq("tp_sum", 64'(sum), 64'h47);
        $display("op tp: 12 + 34 + 1 -> sum=%02h at cycle %0d", sum, cyc);
      end
    end
    in_valid = 1'b0;
    check_eq("tp_accepts", 64'(acc_cyc.size() >= 4), 64'd1);
    for (int i = 1; i < acc_cyc.size(); i++) begin
      check_eq("tp_interval", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd10);
    end
    lat = 0;
    while (!in_ready && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check_eq("tp_drain", 64'(in_ready), 64'd1);

    // Random traffic on both widths in parallel
    fork
      rnd8_run();
      rnd13_run();
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
